// File: rtl/banco_registradores_param.sv
// Parametrised register file: register 0 reads as zero, optional same-cycle
// write-to-read forwarding, and a bulk-clear engine that zeroes one register per cycle.
module banco_registradores_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  write_blocked
);
  // state   | meaning
  // S_IDLE  | normal operation, clear_req starts a clear
  // S_CLEAR | zeroing mem[r_cnt] each cycle, writes dropped
  // S_DONE  | single cycle with clear_done high

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_wr_en;
  logic w_fwd_ok;

  assign w_wr_en  = regWrite & ~r_busy & (write_register != '0);
  assign w_fwd_ok = BYPASS & regWrite & ~r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Clear and write are mutually exclusive: writes are only accepted while not busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else if (w_wr_en) begin
      r_mem[write_register] <= write_data;
    end
  end

  always_comb begin
    read_data_1 = r_mem[read_register_1];
    if (read_register_1 == '0)
      read_data_1 = '0;
    else if (w_fwd_ok && (write_register == read_register_1))
      read_data_1 = write_data;

    read_data_2 = r_mem[read_register_2];
    if (read_register_2 == '0)
      read_data_2 = '0;
    else if (w_fwd_ok && (write_register == read_register_2))
      read_data_2 = write_data;
  end

  assign busy          = r_busy;
  assign clear_done    = r_done;
  assign write_blocked = regWrite & r_busy;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Bench for banco_registradores_param: bypass and non-bypass instances share stimulus
// and are checked every cycle against an array model plus literal expectations.
module tb_banco_registradores_param;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          regWrite = 1'b0;
  logic          clear_req = 1'b0;
  logic [AW-1:0] rr1 = '0;
  logic [AW-1:0] rr2 = '0;
  logic [AW-1:0] wr = '0;
  logic [DW-1:0] wd = '0;

  logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic          busy_b, done_b, wb_b, busy_n, done_n, wb_n;

  always #5 clk = ~clk;

  banco_registradores_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .regWrite(regWrite),
    .read_register_1(rr1), .read_register_2(rr2), .write_register(wr),
    .write_data(wd), .clear_req(clear_req),
    .read_data_1(rd1_b), .read_data_2(rd2_b),
    .busy(busy_b), .clear_done(done_b), .write_blocked(wb_b)
  );

  banco_registradores_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .regWrite(regWrite),
    .read_register_1(rr1), .read_register_2(rr2), .write_register(wr),
    .write_data(wd), .clear_req(clear_req),
    .read_data_1(rd1_n), .read_data_2(rd2_n),
    .busy(busy_n), .clear_done(done_n), .write_blocked(wb_n)
  );

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;

  // Model: register contents plus number of clear cycles still to run.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;
  bit            m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_left = 0;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_mem[DEPTH - m_left] = '0;
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      if (regWrite && wr != '0) m_mem[wr] = wd;
      if (clear_req && !m_done) m_left = DEPTH - 1;
      m_done = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp && regWrite && m_left == 0 && wr == a) return wd;
    return m_mem[a];
  endfunction

  task automatic cmp_model();
    chk("m_rd1_byp", rd1_b, exp_rd(rr1, 1'b1));
    chk("m_rd2_byp", rd2_b, exp_rd(rr2, 1'b1));
    chk("m_rd1_nob", rd1_n, exp_rd(rr1, 1'b0));
    chk("m_rd2_nob", rd2_n, exp_rd(rr2, 1'b0));
    chk("m_busy", DW'(busy_b), DW'(m_left > 0));
    chk("m_busy_n", DW'(busy_n), DW'(m_left > 0));
    chk("m_done", DW'(done_b), DW'(m_done));
    chk("m_done_n", DW'(done_n), DW'(m_done));
    chk("m_wblk", DW'(wb_b), DW'(regWrite && m_left > 0));
    chk("m_wblk_n", DW'(wb_n), DW'(regWrite && m_left > 0));
    if (done_b) done_pulses++;
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_model();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_reg(input int a, input logic [DW-1:0] d);
    regWrite = 1'b1; wr = AW'(a); wd = d;
    tick();
    regWrite = 1'b0;
  endtask

  int n;
  int d0;

  initial begin
    #1 reset = 1'b1;
    repeat (3) tick();
    rr1 = 5'd2; rr2 = 5'd31;
    #1;
    chk("reset_rd1", rd1_b, 32'd0);
    chk("reset_rd2", rd2_n, 32'd0);
    chk("reset_busy", DW'(busy_b), 32'd0);
    reset = 1'b0;
    tick();

    wr_reg(2, 32'd7);
    rr1 = 5'd2; rr2 = 5'd1;
    #1;
    chk("wr_rd1", rd1_b, 32'd7);
    chk("wr_rd2", rd2_b, 32'd0);

    regWrite = 1'b1; wr = '0; wd = 32'hDEADBEEF; rr1 = '0; rr2 = '0;
    #1;
    chk("r0_fwd", rd1_b, 32'd0);
    tick();
    regWrite = 1'b0;
    #1;
    chk("r0_rd1", rd1_b, 32'd0);
    chk("r0_rd2", rd2_n, 32'd0);

    wr_reg(5, 32'd3);
    regWrite = 1'b1; wr = 5'd5; wd = 32'd9; rr1 = 5'd5;
    #1;
    chk("byp_pre", rd1_b, 32'd9);
    chk("nobyp_pre", rd1_n, 32'd3);
    tick();
    regWrite = 1'b0;
    #1;
    chk("byp_post", rd1_b, 32'd9);
    chk("nobyp_post", rd1_n, 32'd9);

    for (int i = 1; i < DEPTH; i++) wr_reg(i, DW'(i));
    rr1 = 5'd17; rr2 = 5'd31;
    #1;
    chk("fill17", rd1_b, 32'd17);
    chk("fill31", rd2_n, 32'd31);

    d0 = done_pulses;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    rr1 = 5'd4; rr2 = 5'd30;
    n = 0;
    while (busy_b && n < 100) begin
      n++;
      if (n == 10) begin
        regWrite = 1'b1; wr = 5'd4; wd = 32'd44;
        #1;
        chk("wblk_mid", DW'(wb_b), 32'd1);
        chk("byp_off_mid", rd1_b, 32'd0);
        chk("rd30_mid", rd2_b, 32'd30);
      end
      if (n == 11) regWrite = 1'b0;
      if (n == 15) clear_req = 1'b1;
      if (n == 16) clear_req = 1'b0;
      tick();
    end
    #1;
    chk("busy_len", DW'(n), 32'd31);
    chk("done_hi", DW'(done_b), 32'd1);
    tick();
    #1;
    chk("done_lo", DW'(done_b), 32'd0);
    chk("done_cnt", DW'(done_pulses - d0), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      rr1 = AW'(i); rr2 = AW'(DEPTH - 1 - i);
      #1;
      chk("cleared", rd1_b, 32'd0);
      tick();
    end

    wr_reg(1, 32'h11);
    wr_reg(2, 32'h22);
    wr_reg(20, 32'h20);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    rr1 = 5'd20; rr2 = 5'd2;
    #1;
    chk("pre_rst20", rd1_b, 32'h20);
    chk("pre_rst2", rd2_b, 32'd0);
    d0 = done_pulses;
    reset = 1'b1;
    #1;
    chk("rst_busy", DW'(busy_b), 32'd0);
    chk("rst_rd20", rd1_b, 32'd0);
    chk("rst_rd20_n", rd1_n, 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_nodone", DW'(done_pulses - d0), 32'd0);

    wr_reg(1, 32'h11);
    wr_reg(2, 32'h22);
    rr1 = 5'd1; rr2 = 5'd2;
    d0 = done_pulses;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (busy_b && n < 100) begin
      n++;
      if (n == 1) begin
        #1;
        chk("restart_r1_before", rd1_b, 32'h11);
      end
      if (n == 2) begin
        #1;
        chk("restart_r1", rd1_b, 32'd0);
        chk("restart_r2", rd2_b, 32'h22);
      end
      tick();
    end
    chk("busy_len2", DW'(n), 32'd31);
    tick();
    tick();
    chk("done_cnt2", DW'(done_pulses - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
